// File: rtl/div255_pkg.sv
// Shared types and constants for the divide-by-255 scheduler slice.
// The divider itself lives outside; only its 16-bit word protocol is described here.
package div255_pkg;

   localparam int DIV255_WORD     = 16;
   localparam int DIV255_DATA     = 32;
   localparam int DIV255_HOLD_DEF = 2;
   localparam int DIV255_WAIT_DEF = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD_HI,
      ST_LD_LO,
      ST_CALC,
      ST_RD_HI,
      ST_RD_LO,
      ST_FIN,
      ST_RSP
   } div255_state_t;

   function automatic int div255_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last winner.
// The last-winner pointer is owned by the caller.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] grant_idx,
   output logic                    grant_any
);

   localparam int IW = $clog2(NREQ);

   always_comb begin
      logic [IW-1:0] idx;
      idx       = '0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IW'((int'(last) + k) % NREQ);
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div255_scheduler.sv
// Shares one word-serial divide-by-255 engine among NREQ requesters, sequencing
// its load / compute / readout flag protocol and returning each quotient to its owner.
module div255_scheduler
   import div255_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int HOLD = DIV255_HOLD_DEF,
   parameter int WAIT = DIV255_WAIT_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [DIV255_DATA*NREQ-1:0] req_data,
   output logic [NREQ-1:0]             req_ready,
   output logic [NREQ-1:0]             rsp_valid,
   output logic [DIV255_DATA-1:0]      rsp_data,
   output logic                        busy,
   output logic [DIV255_WORD-1:0]      div_x,
   output logic                        div_flg1,
   output logic                        div_flg2,
   output logic                        div_flg3,
   output logic                        div_flg4,
   input  logic [DIV255_WORD-1:0]      div_y
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(div255_max(HOLD, WAIT)) + 1;
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
   localparam logic [CW-1:0] WAIT_LD = CW'(WAIT - 1);

   div255_state_t          state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DIV255_DATA-1:0] data_q, data_d;
   logic [DIV255_DATA-1:0] quot_q, quot_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [IW-1:0]          last_q, last_d;

   logic [NREQ-1:0]        arb_grant;
   logic [IW-1:0]          arb_idx;
   logic                   arb_any;
   logic [DIV255_DATA-1:0] sel_data;
   logic                   phase_done;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .req      (req_valid),
      .last     (last_q),
      .grant    (arb_grant),
      .grant_idx(arb_idx),
      .grant_any(arb_any)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_grant[i]) begin
            sel_data = req_data[i*DIV255_DATA +: DIV255_DATA];
         end
      end
   end

   assign phase_done = (cnt_q == '0);

   // last resets to NREQ-1 so that requester 0 wins the first arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         quot_q  <= '0;
         owner_q <= '0;
         last_q  <= IW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         quot_q  <= quot_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = phase_done ? cnt_q : cnt_q - CW'(1);
      data_d  = data_q;
      quot_d  = quot_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               state_d = ST_LD_HI;
               cnt_d   = HOLD_LD;
               data_d  = sel_data;
               owner_d = arb_idx;
               last_d  = arb_idx;
            end
         end
         ST_LD_HI: begin
            if (phase_done) begin
               state_d = ST_LD_LO;
               cnt_d   = HOLD_LD;
            end
         end
         ST_LD_LO: begin
            if (phase_done) begin
               state_d = ST_CALC;
               cnt_d   = WAIT_LD;
            end
         end
         ST_CALC: begin
            if (phase_done) begin
               state_d = ST_RD_HI;
               cnt_d   = HOLD_LD;
            end
         end
         ST_RD_HI: begin
            if (phase_done) begin
               quot_d[31:16] = div_y;
               state_d       = ST_RD_LO;
               cnt_d         = HOLD_LD;
            end
         end
         ST_RD_LO: begin
            if (phase_done) begin
               quot_d[15:0] = div_y;
               state_d      = ST_FIN;
               cnt_d        = HOLD_LD;
            end
         end
         ST_FIN: begin
            if (phase_done) begin
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // req_ready is gated by rst so that no acceptance is shown while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      busy      = (state_q != ST_IDLE);
      div_x     = '0;
      div_flg1  = 1'b0;
      div_flg2  = 1'b0;
      div_flg3  = 1'b0;
      div_flg4  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = rst ? '0 : arb_grant;
         end
         ST_LD_HI: begin
            div_x    = data_q[31:16];
            div_flg1 = 1'b1;
         end
         ST_LD_LO: begin
            div_x    = data_q[15:0];
            div_flg2 = 1'b1;
         end
         ST_CALC, ST_RD_HI: begin
            div_x = data_q[15:0];
         end
         ST_RD_LO: begin
            div_x    = data_q[15:0];
            div_flg3 = 1'b1;
         end
         ST_FIN: begin
            div_x    = data_q[15:0];
            div_flg4 = 1'b1;
         end
         ST_RSP: begin
            for (int i = 0; i < NREQ; i++) begin
               rsp_valid[i] = (owner_q == IW'(i));
            end
            rsp_data = quot_q;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_div255_scheduler.sv
// Scoreboard bench for div255_scheduler with a behavioural divide-by-255 engine
// attached to the divider port; expected grants and quotients are hand-computed.
module tb_div255_scheduler;
   import div255_pkg::*;

   localparam int NREQ = 2;
   localparam int HOLD = 2;
   localparam int WAIT = 6;
   localparam int LAT  = 17;

   logic                        clk = 1'b0;
   logic                        rst;
   logic [NREQ-1:0]             req_valid;
   logic [DIV255_DATA*NREQ-1:0] req_data;
   logic [NREQ-1:0]             req_ready;
   logic [NREQ-1:0]             rsp_valid;
   logic [DIV255_DATA-1:0]      rsp_data;
   logic                        busy;
   logic [DIV255_WORD-1:0]      div_x;
   logic                        div_flg1, div_flg2, div_flg3, div_flg4;
   logic [DIV255_WORD-1:0]      div_y;

   typedef struct {
      int          owner;
      logic [31:0] data;
   } rsp_exp_t;

   rsp_exp_t rsp_q[$];
   int       grant_q[$];
   int       checks = 0;
   int       passes = 0;
   int       cyc = 0;
   int       grant_count = 0;
   int       last_grant_cyc = 0;
   int       last_rsp_cyc = 0;
   bit       b2b_armed = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   div255_scheduler #(
      .NREQ(NREQ),
      .HOLD(HOLD),
      .WAIT(WAIT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_data (rsp_data),
      .busy     (busy),
      .div_x    (div_x),
      .div_flg1 (div_flg1),
      .div_flg2 (div_flg2),
      .div_flg3 (div_flg3),
      .div_flg4 (div_flg4),
      .div_y    (div_y)
   );

   // Behavioural divider: loads two words, then reads out Q[31:16] unless flg3 selects Q[15:0].
   logic [15:0] m_hi, m_lo;
   logic [31:0] m_q;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_hi <= '0;
         m_lo <= '0;
      end else begin
         if (div_flg1) m_hi <= div_x;
         if (div_flg2) m_lo <= div_x;
      end
   end
   assign m_q   = {m_hi, m_lo} / 32'd255;
   assign div_y = div_flg3 ? m_q[15:0] : m_q[31:16];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic report_fail(input string name, input logic [63:0] act);
      checks++;
      $display("[TB] FAIL %s: got 0x%0h, expected none (cycle %0d)", name, act, cyc);
   endtask

   task automatic push_job(input int owner, input logic [31:0] quot);
      rsp_exp_t e;
      e.owner = owner;
      e.data  = quot;
      grant_q.push_back(owner);
      rsp_q.push_back(e);
   endtask

   task automatic apply_stimulus(input int idx, input logic [31:0] data);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      req_valid[idx]            = 1'b1;
      req_data[idx*32 +: 32]    = data;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (req_ready[idx]) ok = 1'b1;
      end
      if (!ok) report_fail("grant_timeout", req_ready);
      @(posedge clk); #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk); #1;
         if (rsp_q.size() == 0 && grant_q.size() == 0 && !busy) ok = 1'b1;
      end
      if (!ok) report_fail("drain_timeout", rsp_q.size());
      repeat (2) @(posedge clk);
   endtask

   // Monitor: grants, responses and divider flag protocol, sampled on the falling edge.
   initial begin
      int          g;
      rsp_exp_t    e;
      logic [3:0]  flags, prev;
      int          run[4];
      int          last_rise;
      int          flg2_fall_cyc;
      prev = '0;
      last_rise = -1;
      flg2_fall_cyc = 0;
      for (int f = 0; f < 4; f++) run[f] = 0;
      forever begin
         @(negedge clk);
         flags = {div_flg4, div_flg3, div_flg2, div_flg1};
         if (rst) begin
            prev = '0;
            last_rise = -1;
            for (int f = 0; f < 4; f++) run[f] = 0;
         end else begin
            if (|req_ready) begin
               grant_count++;
               check_output("grant_not_in_rsp", rsp_valid, 0);
               if (grant_q.size() == 0) report_fail("unexpected_grant", req_ready);
               else begin
                  g = grant_q.pop_front();
                  check_output("grant_owner", req_ready, 64'(1) << g);
               end
               if (b2b_armed) begin
                  check_output("b2b_gap", cyc - last_rsp_cyc, 1);
                  b2b_armed = 1'b0;
               end
               last_grant_cyc = cyc;
            end
            if (|rsp_valid) begin
               if (rsp_q.size() == 0) report_fail("unexpected_rsp", rsp_valid);
               else begin
                  e = rsp_q.pop_front();
                  check_output("rsp_owner", rsp_valid, 64'(1) << e.owner);
                  check_output("rsp_data", rsp_data, e.data);
                  check_output("rsp_latency", cyc - last_grant_cyc, LAT);
               end
               last_rsp_cyc = cyc;
            end
            if (|flags) check_output("flag_onehot", $countones(flags) <= 1, 1);
            for (int f = 0; f < 4; f++) begin
               if (flags[f] && !prev[f]) begin
                  if (f == 0) check_output("flag_order", (last_rise == -1 || last_rise == 3), 1);
                  else check_output("flag_order", last_rise, f - 1);
                  if (f == 2) check_output("calc_gap", cyc - flg2_fall_cyc, WAIT + HOLD);
                  last_rise = f;
               end
               if (flags[f]) run[f]++;
               else if (run[f] != 0) begin
                  check_output("flag_len", run[f], HOLD);
                  run[f] = 0;
                  if (f == 1) flg2_fall_cyc = cyc;
               end
            end
            prev = flags;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  start;
      bit  ok;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_outputs",
                   {req_ready, rsp_valid, rsp_data, busy, div_x,
                    div_flg4, div_flg3, div_flg2, div_flg1}, 0);
      rst = 1'b0;

      $display("[TB] contention");
      push_job(0, 32'h01010101);
      push_job(1, 32'h00000000);
      push_job(0, 32'h01010101);
      push_job(1, 32'h00000000);
      start = grant_count;
      @(posedge clk); #1;
      req_data  = {32'h00000000, 32'hFFFFFFFF};
      req_valid = 2'b11;
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk); #1;
         if (grant_count == start + 4) ok = 1'b1;
      end
      if (!ok) report_fail("contention_timeout", grant_count - start);
      @(posedge clk); #1;
      req_valid = '0;
      wait_done();

      $display("[TB] single job");
      push_job(0, 32'h000000FF);
      apply_stimulus(0, 32'h0000FE01);
      wait_done();

      $display("[TB] flag protocol");
      push_job(0, 32'h00010001);
      apply_stimulus(0, 32'h00FF00FF);
      wait_done();

      $display("[TB] back-to-back");
      push_job(1, 32'h00000002);
      apply_stimulus(1, 32'h000001FE);
      repeat (15) @(posedge clk);
      push_job(1, 32'h0012469D);
      b2b_armed = 1'b1;
      apply_stimulus(1, 32'h12345678);
      wait_done();
      check_output("b2b_consumed", b2b_armed, 0);

      $display("[TB] withdrawn request");
      start = grant_count;
      push_job(0, 32'h00000001);
      apply_stimulus(0, 32'h00000100);
      repeat (3) @(posedge clk);
      #1;
      req_data[63:32] = 32'hDEADBEEF;
      req_valid[1]    = 1'b1;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      wait_done();
      check_output("withdrawn_grants", grant_count - start, 1);

      $display("[TB] reset mid-job");
      grant_q.push_back(0);
      apply_stimulus(0, 32'h87654321);
      repeat (7) @(posedge clk);
      #1;
      req_data  = {32'h0000FFFF, 32'h0000FE01};
      req_valid = 2'b11;
      rst       = 1'b1;
      #1;
      check_output("reset_mid_outputs",
                   {req_ready, rsp_valid, rsp_data, busy, div_x,
                    div_flg4, div_flg3, div_flg2, div_flg1}, 0);
      repeat (2) @(posedge clk);
      push_job(0, 32'h000000FF);
      #1;
      rst = 1'b0;
      ok  = 1'b0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (|req_ready) ok = 1'b1;
      end
      if (!ok) report_fail("post_reset_grant_timeout", req_ready);
      @(posedge clk); #1;
      req_valid = '0;
      wait_done();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
